// File: rtl/sequenced_datapath.sv
// sequenced_datapath
// A small multi-cycle datapath: a general-purpose register file, an
// accumulator-style operand register Y, a double-width result register Z and
// a HI/LO pair for multiply results, all moved over one internal bus under
// control of a five-state sequencer (IDLE -> LOADY -> CALC -> WB -> DONE).
//
// Ports
//   clk, clr            clock; synchronous active-high clear
//   start, op           request one operation (accepted in IDLE only), op code
//   ra, rb, rc          destination, first and second operand register addresses
//   ld_en/addr/data     external register-file write port (honoured in IDLE only)
//   rd_addr, rd_data    combinational register-file read port
//   busy, done, err     sequencer status; done/err are one-cycle pulses
//   hi_out, lo_out,
//   y_out, bus_out      internal values exported for observation
module sequenced_datapath #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] bus_out
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHRA = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_ROR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_NEG  = 4'd9;
  localparam logic [3:0] OP_NOT  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  typedef enum logic [2:0] {S_IDLE, S_LOADY, S_CALC, S_WB, S_DONE} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   y_q, hi_q, lo_q;
  logic [2*WIDTH-1:0] z_q;
  logic [3:0]         op_q;
  logic [AW-1:0]      ra_q, rb_q, rc_q;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;
  logic               latch_en, ld_we, y_we, z_we, gpr_we, hilo_we;
  logic               legal, is_mul;

  assign legal  = (op_q < 4'd12);
  assign is_mul = (op_q == OP_MUL);

  // ---------------- sequencer: state register ----------------
  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- sequencer: next state ----------------
  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_LOADY;
      S_LOADY: state_d = S_CALC;
      S_CALC:  state_d = S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- sequencer: outputs and bus steering ----------------
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    bus      = '0;
    latch_en = 1'b0;
    ld_we    = 1'b0;
    y_we     = 1'b0;
    z_we     = 1'b0;
    gpr_we   = 1'b0;
    hilo_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy     = 1'b0;
        latch_en = start;
        ld_we    = ld_en;
      end
      S_LOADY: begin
        bus  = regs_q[rb_q];
        y_we = 1'b1;
      end
      S_CALC: begin
        bus  = regs_q[rc_q];
        z_we = 1'b1;
      end
      S_WB: begin
        bus     = z_q[WIDTH-1:0];
        gpr_we  = legal && !is_mul;
        hilo_we = legal && is_mul;
      end
      S_DONE: begin
        done = 1'b1;
        err  = !legal;
      end
      default: busy = 1'b0;
    endcase
  end

  // ---------------- ALU: A = Y, B = bus ----------------
  always_comb begin
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] res;
    shamt   = bus[SW-1:0];
    res     = '0;
    alu_res = '0;
    unique case (op_q)
      OP_ADD:  res = y_q + bus;
      OP_SUB:  res = y_q - bus;
      OP_AND:  res = y_q & bus;
      OP_OR:   res = y_q | bus;
      OP_SHR:  res = y_q >> shamt;
      OP_SHRA: res = $signed(y_q) >>> shamt;
      OP_SHL:  res = y_q << shamt;
      // A shift by WIDTH yields zero, so a rotate by 0 degenerates cleanly.
      OP_ROR:  res = (y_q >> shamt) | (y_q << (WIDTH - int'(shamt)));
      OP_ROL:  res = (y_q << shamt) | (y_q >> (WIDTH - int'(shamt)));
      OP_NEG:  res = '0 - bus;
      OP_NOT:  res = ~bus;
      default: res = '0;
    endcase
    if (is_mul)
      // Sign-extended operands make the modulo-2^(2W) product the signed one.
      alu_res = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};
    else
      alu_res = {{WIDTH{1'b0}}, res};
  end

  // ---------------- datapath registers ----------------
  // NOTE: the register file is cleared by reset, which forces flops rather
  // than a RAM macro; that is intended for a file this small.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      y_q  <= '0;
      z_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      op_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rc_q <= '0;
    end else begin
      if (latch_en) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      // Load and WB write never coincide: one is IDLE-only, the other WB-only.
      if (ld_we)  regs_q[ld_addr] <= ld_data;
      if (gpr_we) regs_q[ra_q]    <= bus;
      if (y_we)   y_q <= bus;
      if (z_we)   z_q <= alu_res;
      if (hilo_we) begin
        hi_q <= z_q[2*WIDTH-1:WIDTH];
        lo_q <= z_q[WIDTH-1:0];
      end
    end
  end

  assign rd_data = regs_q[rd_addr];
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;
  assign y_out   = y_q;
  assign bus_out = bus;

endmodule

// File: tb/tb_sequenced_datapath.sv
`timescale 1ns/1ps
module tb_sequenced_datapath;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = '0;
  logic [3:0]  ra = '0, rb = '0, rc = '0;
  logic        ld_en = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] rd_data, hi_out, lo_out, y_out, bus_out;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo;

  sequenced_datapath dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err), .hi_out(hi_out),
    .lo_out(lo_out), .y_out(y_out), .bus_out(bus_out)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from the op-code table; returns the full 64-bit Z.
  function automatic logic [63:0] ref_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    int unsigned s;
    logic [63:0] dbl, tmp;
    longint      p;
    s   = b % 32;
    dbl = {a, a};
    case (o)
      4'd0:  return {32'd0, a + b};
      4'd1:  return {32'd0, a - b};
      4'd2:  return {32'd0, a & b};
      4'd3:  return {32'd0, a | b};
      4'd4:  return {32'd0, a >> s};
      4'd5:  begin tmp = 64'($signed(a) >>> s); return {32'd0, tmp[31:0]}; end
      4'd6:  return {32'd0, a << s};
      4'd7:  begin tmp = dbl >> s; return {32'd0, tmp[31:0]}; end
      4'd8:  begin tmp = dbl << s; return {32'd0, tmp[63:32]}; end
      4'd9:  return {32'd0, 32'd0 - b};
      4'd10: return {32'd0, ~b};
      4'd11: begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
      default: return 64'd0;
    endcase
  endfunction

  task automatic read_reg(input logic [3:0] a, output logic [31:0] v);
    rd_addr = a;
    #1;
    v = rd_data;
  endtask

  task automatic check_regs(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      read_reg(4'(i), v);
      check($sformatf("%s_r%0d", tag, i), v, m_r[i]);
    end
    check({tag, "_hi"}, hi_out, m_hi);
    check({tag, "_lo"}, lo_out, m_lo);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
    m_r[a] = d;
  endtask

  // One operation. Optionally loads (ld) in the start cycle, and optionally
  // pokes start + ld_en while busy (both must be ignored).
  task automatic run_op(input string tag, input logic [3:0] o, input logic [3:0] a_,
                        input logic [3:0] b_, input logic [3:0] c_, input bit ld,
                        input logic [3:0] ld_a, input logic [31:0] ld_d, input bit poke);
    int cyc, bc, extra;
    logic [63:0] z;
    logic [31:0] opa;
    start = 1'b1; op = o; ra = a_; rb = b_; rc = c_;
    ld_en = ld; ld_addr = ld_a; ld_data = ld_d;
    if (ld) m_r[ld_a] = ld_d;
    opa = m_r[b_];
    z   = ref_alu(o, opa, m_r[c_]);
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    bc  = busy ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 8) begin
      if (poke && cyc == 1) begin
        start = 1'b1; op = 4'd0; ld_en = 1'b1; ld_addr = 4'(a_ + 4'd1); ld_data = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      start = 1'b0; ld_en = 1'b0;
      cyc++;
      if (busy) bc++;
    end
    check({tag, "_latency"}, cyc, 3);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_err"}, err, (o >= 4'd12) ? 1'b1 : 1'b0);
    @(posedge clk); #1;
    check({tag, "_busy_cycles"}, bc, 4);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_bus"}, bus_out, 32'd0);
    if (poke) begin
      extra = 0;
      repeat (5) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, "_extra_done"}, extra, 0);
    end
    if (o == 4'd11) begin
      m_hi = z[63:32];
      m_lo = z[31:0];
    end else if (o < 4'd12) begin
      m_r[a_] = z[31:0];
    end
    check({tag, "_y"}, y_out, opa);
    check_regs(tag);
  endtask

  initial begin
    logic [31:0] v;
    int          extra;
    model_reset();

    // Reset
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bus", bus_out, 32'd0);
    check("rst_y", y_out, 32'd0);
    check_regs("rst");

    // Basic ADD: R1 = 5 + 7
    load(4'd2, 32'd5);
    load(4'd3, 32'd7);
    run_op("add", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    read_reg(4'd1, v);
    check("add_r1_is_12", v, 32'd12);

    // Rotate / arithmetic shift / shift left boundary patterns
    load(4'd2, 32'h8000_0001);
    load(4'd3, 32'd1);
    run_op("ror", 4'd7, 4'd4, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    read_reg(4'd4, v);
    check("ror_r4", v, 32'hC000_0000);
    run_op("shra", 4'd5, 4'd4, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    read_reg(4'd4, v);
    check("shra_r4", v, 32'hC000_0000);
    run_op("shl", 4'd6, 4'd4, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    read_reg(4'd4, v);
    check("shl_r4", v, 32'h0000_0002);

    // Signed multiply into HI/LO; no GPR write
    load(4'd2, 32'hFFFF_FFFD);
    load(4'd3, 32'd4);
    run_op("mul", 4'd11, 4'd5, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    check("mul_hi", hi_out, 32'hFFFF_FFFF);
    check("mul_lo", lo_out, 32'hFFFF_FFF4);

    // Illegal op, with start and ld_en poked while busy
    run_op("illegal", 4'd13, 4'd6, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b1);

    // clr during CALC of an ADD
    start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
    check("clr_busy", busy, 1'b0);
    check("clr_done", done, 1'b0);
    check("clr_bus", bus_out, 32'd0);
    check("clr_y", y_out, 32'd0);
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("clr_no_done", extra, 0);
    check_regs("clr");
    load(4'd2, 32'd3);
    load(4'd3, 32'd4);
    run_op("post_clr", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);

    // Load in the start cycle feeds the operand read
    load(4'd2, 32'd10);
    run_op("ld_start", 4'd0, 4'd6, 4'd2, 4'd3, 1'b1, 4'd3, 32'd100, 1'b0);
    read_reg(4'd6, v);
    check("ld_start_r6", v, 32'd110);

    // Destination equals a source: old operand values are used
    run_op("ra_eq_rb", 4'd1, 4'd2, 4'd2, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      load(4'($urandom_range(0, 15)), $urandom);
      load(4'($urandom_range(0, 15)), $urandom);
      run_op($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
